i2c_config_seq: RTL and testbench

Register-initialisation sequencer for the camera path. It sits directly upstream of the I2C master and walks a configuration LUT of {register address, data} entries. For each entry it issues one write request to the master and waits for the master's acknowledge. It retries on NACK, inserts programmable delays for special entries, and reports done or failure to the camera bring-up logic.

---
 rtl/i2c_config_seq.sv | 173 +++++++++++++++++
 tb/tb_i2c_config_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_seq.sv
// rtl/i2c_config_seq.sv - camera register-init sequencer: walks a {reg_addr, data} LUT and issues I2C writes
// Retries NACKed writes, honours delay entries, and reports done/failure to bring-up logic.
module i2c_config_seq #(
    parameter int          LUT_DEPTH      = 256,
    parameter int          IDX_W          = 8,
    parameter logic [19:0] POWERUP_CYCLES = 20'd1_000_000,
    parameter logic [15:0] DELAY_UNIT     = 16'd50_000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] lut_index,
    input  logic [23:0]      lut_data,
    output logic             i2c_write_req,
    input  logic             i2c_write_req_ack,
    input  logic             i2c_error,
    output logic [15:0]      i2c_slave_reg_addr,
    output logic [7:0]       i2c_write_data,
    output logic             config_busy,
    output logic             config_done,
    output logic             config_error,
    output logic [IDX_W-1:0] fail_index
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
    localparam int DW = IDX_W + 1;
    localparam logic [DW-1:0] DEPTH_X = DW'(LUT_DEPTH);
    localparam logic [DW-1:0] LAST_X = DW'(LUT_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    // When LUT_DEPTH fills the whole index range, the index saturates instead of wrapping.
    localparam bit IDX_ROOM = (LUT_DEPTH < (1 << IDX_W));

    typedef enum logic [2:0] {
        S_POWERUP,
        S_FETCH,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] lut_index_q, lut_index_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             req_q, req_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [IDX_W-1:0] fail_index_q, fail_index_d;

    logic [15:0]   fetch_addr;
    logic [7:0]    fetch_data;
    logic [DW-1:0] idx_x;
    logic [23:0]   delay_prod;

    assign fetch_addr = lut_data[23:8];
    assign fetch_data = lut_data[7:0];
    assign idx_x      = {1'b0, lut_index_q};
    assign delay_prod = 24'(fetch_data) * 24'(DELAY_UNIT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lut_index_d  = lut_index_q;
        retry_d      = retry_q;
        req_d        = req_q;
        addr_d       = addr_q;
        data_d       = data_q;
        fail_index_d = fail_index_q;
        case (state_q)
            S_POWERUP: begin
                cnt_d = cnt_q + 24'd1;
                if ((cnt_q + 24'd1) >= {4'd0, POWERUP_CYCLES}) begin
                    state_d     = S_FETCH;
                    cnt_d       = 24'd0;
                    lut_index_d = '0;
                    retry_d     = '0;
                end
            end
            S_FETCH: begin
                if ((idx_x >= DEPTH_X) || (fetch_addr == 16'hFFFF)) begin
                    state_d = S_DONE;
                end else if (fetch_addr == 16'hFFFE) begin
                    if (fetch_data == 8'd0) begin
                        state_d = S_NEXT;
                    end else begin
                        cnt_d   = delay_prod;
                        state_d = S_DELAY;
                    end
                end else begin
                    addr_d  = fetch_addr;
                    data_d  = fetch_data;
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i2c_write_req_ack) begin
                    req_d = 1'b0;
                    if (!i2c_error) begin
                        state_d = S_NEXT;
                    end else if (retry_q < MAX_R) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_FETCH;
                    end else begin
                        fail_index_d = lut_index_q;
                        state_d      = S_FAIL;
                    end
                end
            end
            S_DELAY: begin
                cnt_d = cnt_q - 24'd1;
                if (cnt_q <= 24'd1) begin
                    cnt_d   = 24'd0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (!IDX_ROOM && (idx_x == LAST_X)) begin
                    state_d = S_DONE;
                end else begin
                    lut_index_d = lut_index_q + IDX_ONE;
                    state_d     = S_FETCH;
                end
            end
            S_DONE, S_FAIL: begin
                if (start) begin
                    state_d     = S_POWERUP;
                    cnt_d       = 24'd0;
                    lut_index_d = '0;
                    retry_d     = '0;
                end
            end
            default: state_d = S_POWERUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_POWERUP;
            cnt_q        <= 24'd0;
            lut_index_q  <= '0;
            retry_q      <= '0;
            req_q        <= 1'b0;
            addr_q       <= 16'd0;
            data_q       <= 8'd0;
            fail_index_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lut_index_q  <= lut_index_d;
            retry_q      <= retry_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            fail_index_q <= fail_index_d;
        end
    end

    assign lut_index          = lut_index_q;
    assign i2c_write_req      = req_q;
    assign i2c_slave_reg_addr = addr_q;
    assign i2c_write_data     = data_q;
    assign fail_index         = fail_index_q;
    assign config_busy        = (state_q != S_DONE) && (state_q != S_FAIL);
    assign config_done        = (state_q == S_DONE);
    assign config_error       = (state_q == S_FAIL);

endmodule

// File: tb/tb_i2c_config_seq.sv
// tb/tb_i2c_config_seq.sv - table-driven bench for i2c_config_seq with a small I2C master model
module tb_i2c_config_seq;

    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic        req;
    logic        ack;
    logic        err;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        busy, done, cerr;
    logic [7:0]  fail_index;

    logic [3:0][23:0] cur_lut;

    i2c_config_seq #(
        .LUT_DEPTH(4),
        .IDX_W(8),
        .POWERUP_CYCLES(20'd10),
        .DELAY_UNIT(16'd4),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .lut_index(lut_index),
        .lut_data(lut_data),
        .i2c_write_req(req),
        .i2c_write_req_ack(ack),
        .i2c_error(err),
        .i2c_slave_reg_addr(addr),
        .i2c_write_data(data),
        .config_busy(busy),
        .config_done(done),
        .config_error(cerr),
        .fail_index(fail_index)
    );

    always #5 clk = ~clk;

    // Out-of-range reads return a non-marker word so only the depth limit can end the walk.
    assign lut_data = (lut_index < 8'd4) ? cur_lut[lut_index[1:0]] : 24'h123456;

    typedef struct {
        string            name;
        logic [3:0][23:0] lut;
        int               nack_idx;
        int               nack_cnt;
        int               exp_reqs;
        logic             exp_done;
        logic             exp_err;
        logic [7:0]       exp_fail;
        logic [7:0]       exp_idx;
        int               exp_gap0;
    } vec_t;

    vec_t vecs [7];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nack_idx = -1;
    int nack_left = 0;
    int lat;
    logic prev_req;
    logic [23:0] log_q [$];
    logic [23:0] exp_q [$];
    int          rise_q [$];
    int          ackn_q [$];
    logic        ackerr_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [23:0] e0, input logic [23:0] e1,
                                input logic [23:0] e2, input logic [23:0] e3, input int ni,
                                input int nc, input int reqs, input logic dn, input logic er,
                                input logic [7:0] fi, input logic [7:0] ix, input int gap);
        vec_t v;
        v.name = n;
        v.lut[0] = e0; v.lut[1] = e1; v.lut[2] = e2; v.lut[3] = e3;
        v.nack_idx = ni; v.nack_cnt = nc; v.exp_reqs = reqs;
        v.exp_done = dn; v.exp_err = er; v.exp_fail = fi; v.exp_idx = ix; v.exp_gap0 = gap;
        return v;
    endfunction

    task automatic build_exp(input logic [3:0][23:0] lut, input int ni, input int nc);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            int att;
            if (lut[i][23:8] == 16'hFFFF) break;
            if (lut[i][23:8] == 16'hFFFE) continue;
            att = (i == ni) ? ((nc > MAX_RETRY) ? MAX_RETRY + 1 : nc + 1) : 1;
            for (int a = 0; a < att; a++) exp_q.push_back(lut[i]);
            if (i == ni && nc > MAX_RETRY) break;
        end
    endtask

    task automatic clear_logs();
        log_q.delete(); rise_q.delete(); ackn_q.delete(); ackerr_q.delete();
    endtask

    task automatic wait_end(input string name);
        for (int k = 0; k < 600 && !(done || cerr); k++) @(negedge clk);
        check({name, "_timeout"}, done || cerr, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Master model: acks 5 cycles after seeing req, NACKing the chosen entry nack_left times.
    initial begin
        ack = 0; err = 0; prev_req = 0; lat = 0;
        forever begin
            @(negedge clk);
            ack = 0; err = 0;
            if (req && !prev_req) rise_q.push_back(cyc);
            prev_req = req;
            if (rst || !req) begin
                lat = 0;
            end else begin
                lat++;
                if (lat == 5) begin
                    ack = 1;
                    if (int'(lut_index) == nack_idx && nack_left > 0) begin
                        err = 1;
                        nack_left--;
                    end
                    log_q.push_back({addr, data});
                    ackn_q.push_back(cyc);
                    ackerr_q.push_back(err);
                    lat = 0;
                end
            end
        end
    end

    initial begin
        int c0;
        rst = 1; start = 0;
        vecs[0] = mk("basic",   24'h300882, 24'h310303, 24'hFFFF00, 24'h000000, -1, 0, 2, 1, 0, 0, 2, 3);
        vecs[1] = mk("retry2",  24'h300882, 24'h310303, 24'hFFFF00, 24'h000000,  1, 2, 4, 1, 0, 0, 2, 3);
        vecs[2] = mk("fail1",   24'h300882, 24'h310303, 24'hFFFF00, 24'h000000,  1, 4, 5, 0, 1, 1, 1, 3);
        vecs[3] = mk("fail0",   24'h300882, 24'h310303, 24'hFFFF00, 24'h000000,  0, 5, 4, 0, 1, 0, 0, 2);
        vecs[4] = mk("nomark",  24'h100011, 24'h100122, 24'h100233, 24'h100344, -1, 0, 4, 1, 0, 0, 4, 3);
        vecs[5] = mk("delay",   24'h300882, 24'hFFFE03, 24'h310303, 24'hFFFF00, -1, 0, 2, 1, 0, 0, 3, 3 + (1 + 3 * 4 + 1));
        vecs[6] = mk("delay0",  24'h300882, 24'hFFFE00, 24'h310303, 24'hFFFF00, -1, 0, 2, 1, 0, 0, 3, 5);
        cur_lut = vecs[0].lut;
        repeat (2) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_err", cerr, 0);
        check("rst_idx", lut_index, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_fail", fail_index, 0);

        for (int v = 0; v < 7; v++) begin
            cur_lut = vecs[v].lut;
            nack_idx = vecs[v].nack_idx;
            nack_left = vecs[v].nack_cnt;
            build_exp(vecs[v].lut, vecs[v].nack_idx, vecs[v].nack_cnt);
            clear_logs();
            if (v == 0) begin
                rst = 0;
                c0 = cyc;
            end else begin
                start = 1;
                @(negedge clk);
                start = 0;
                check({vecs[v].name, "_restart_busy"}, {busy, done, cerr}, 3'b100);
                check({vecs[v].name, "_restart_idx"}, lut_index, 0);
            end
            wait_end(vecs[v].name);
            repeat (20) @(negedge clk);
            check({vecs[v].name, "_done"}, done, vecs[v].exp_done);
            check({vecs[v].name, "_err"}, cerr, vecs[v].exp_err);
            check({vecs[v].name, "_busy"}, busy, 0);
            check({vecs[v].name, "_idx"}, lut_index, vecs[v].exp_idx);
            check({vecs[v].name, "_req_low"}, req, 0);
            if (vecs[v].exp_err) check({vecs[v].name, "_fail_index"}, fail_index, vecs[v].exp_fail);
            check({vecs[v].name, "_reqs"}, rise_q.size(), vecs[v].exp_reqs);
            check({vecs[v].name, "_writes"}, log_q.size(), exp_q.size());
            for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
                check({vecs[v].name, "_write_word"}, log_q[i], exp_q[i]);
            if (rise_q.size() > 1 && ackn_q.size() > 0)
                check({vecs[v].name, "_gap0"}, rise_q[1] - ackn_q[0], vecs[v].exp_gap0);
            if (v == 0 && rise_q.size() > 0)
                check("first_req_cycle", rise_q[0] - c0, 11);
            // Retry requests follow the ack 2 cycles later, fresh entries 3 cycles later.
            if (v == 1)
                for (int k = 0; k + 1 < rise_q.size() && k < ackn_q.size(); k++)
                    check("retry_gap", rise_q[k + 1] - ackn_q[k], ackerr_q[k] ? 2 : 3);
        end

        cur_lut = vecs[0].lut;
        nack_idx = -1;
        nack_left = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 100 && !req; k++) @(negedge clk);
        check("mid_req_seen", req, 1);
        @(posedge clk);
        #1 rst = 1;
        #1;
        check("mid_rst_req", req, 0);
        check("mid_rst_flags", {busy, done, cerr}, 3'b100);
        check("mid_rst_idx", lut_index, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_data", data, 0);
        @(negedge clk);
        clear_logs();
        rst = 0;
        wait_end("after_rst");
        check("after_rst_done", done, 1);
        check("after_rst_writes", log_q.size(), 2);
        clear_logs();
        start = 1;
        @(negedge clk);
        start = 0;
        check("rerun_idx", lut_index, 0);
        check("rerun_flags", {busy, done, cerr}, 3'b100);
        wait_end("rerun");
        check("rerun_done", done, 1);
        check("rerun_idx_end", lut_index, 2);
        check("rerun_writes", log_q.size(), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
